max_scan_ctrl: RTL

//  Sequencer that finds the largest valid key in a small register file of N

---
 rtl/max_scan_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/max_scan_ctrl.sv
// rtl/max_scan_ctrl.sv - sequential max-key search over a small entry file using one shared comparator
//
// Purpose: holds N (key, valid) entries and, on start, walks them one per
// clock through a single unsigned greater-than comparator. It reports the
// largest valid key and its index (lowest index wins ties).
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   wr_en/wr_idx/     entry write port; accepted only in IDLE and only
//   wr_key/wr_vld     when wr_idx < N (wr_vld=0 deletes the entry)
//   start             scan request, sampled only in IDLE
//   busy              high in SCAN and DONE
//   done              one-cycle pulse; result outputs are valid from here on
//   found/max_key/    result of the last completed scan, held until the
//   max_idx           next done

module cmp_mag #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         a_gt_b
);
  assign a_gt_b = (a > b);
endmodule

module max_scan_ctrl #(
  parameter int W  = 8,
  parameter int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [W-1:0]  wr_key,
  input  logic          wr_vld,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic [W-1:0]  max_key,
  output logic [IW-1:0] max_idx
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [IW:0]   N_EXT = (IW+1)'(N);
  localparam logic [IW-1:0] LAST  = IW'(N - 1);

  state_t          state;
  logic [W-1:0]    key_q [N];
  logic [N-1:0]    vld_q;
  logic [IW-1:0]   cnt;
  logic            best_found;
  logic [W-1:0]    best_key;
  logic [IW-1:0]   best_idx;

  logic [W-1:0]    cur_key;
  logic            cur_vld;
  logic            a_gt_b;
  logic            upd;

  assign cur_key = key_q[cnt];
  assign cur_vld = vld_q[cnt];

  cmp_mag #(.W(W)) u_cmp (
    .a      (cur_key),
    .b      (best_key),
    .a_gt_b (a_gt_b)
  );

  // Strict greater-than keeps the earlier index on equal keys; the first
  // valid entry is always taken regardless of the compare.
  always_comb begin
    upd = 1'b0;
    if (cur_vld && (!best_found || a_gt_b)) upd = 1'b1;
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Entry file: frozen whenever a scan is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) key_q[i] <= '0;
      vld_q <= '0;
    end else if (wr_en && state == IDLE && {1'b0, wr_idx} < N_EXT) begin
      key_q[wr_idx] <= wr_key;
      vld_q[wr_idx] <= wr_vld;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      best_found <= 1'b0;
      best_key   <= '0;
      best_idx   <= '0;
      found      <= 1'b0;
      max_key    <= '0;
      max_idx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= SCAN;
            cnt        <= '0;
            best_found <= 1'b0;
            best_key   <= '0;
            best_idx   <= '0;
          end
        end
        SCAN: begin
          if (upd) begin
            best_found <= 1'b1;
            best_key   <= cur_key;
            best_idx   <= cnt;
          end
          if (cnt == LAST) begin
            // Results must include the last entry, which is compared on
            // this same edge, so load from the post-update values.
            state   <= DONE;
            found   <= upd | best_found;
            max_key <= upd ? cur_key : best_key;
            max_idx <= upd ? cnt : best_idx;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
